// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: in-order pipeline backbone with forwarding, load-use stall, hold and kill; define PIPE_PERF_CNT_EN to add perf counters
module pipe_ctrl_chain #(
  parameter int STAGES = 3,
  parameter int PAYLOAD_W = 64,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RES_AVAIL = 1,
  parameter int LOAD_AVAIL = 2,
  parameter int BR_STAGE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic [REG_AW-1:0]           in_rd,
  input  logic [REG_AW-1:0]           in_rs1,
  input  logic [REG_AW-1:0]           in_rs2,
  input  logic                        in_regwrite,
  input  logic                        in_is_load,
  input  logic                        hold,
  input  logic                        kill,
  input  logic [STAGES*DATA_W-1:0]    stage_result,
  input  logic [DATA_W-1:0]           rf_a,
  input  logic [DATA_W-1:0]           rf_b,
  output logic [DATA_W-1:0]           opa,
  output logic [DATA_W-1:0]           opb,
  output logic                        fwd_a_hit,
  output logic                        fwd_b_hit,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*PAYLOAD_W-1:0] stage_payload,
  output logic                        wb_en,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]                 perf_retired,
  output logic [31:0]                 perf_stall_cyc,
  output logic [31:0]                 perf_kill_cyc,
`endif
  output logic [REG_AW-1:0]           wb_rd
);
  logic [STAGES-1:0] v, rw, ld;
  logic [PAYLOAD_W-1:0] pl [STAGES];
  logic [REG_AW-1:0] rd [STAGES];
  logic [REG_AW-1:0] rs1, rs2;
  logic stall;
  logic unused_res;
  assign unused_res = ^stage_result[DATA_W-1:0];
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < STAGES; k++)
      if (in_valid && v[k] && rw[k] && rd[k] != '0 && (rd[k] == in_rs1 || rd[k] == in_rs2) &&
          k + 1 < (ld[k] ? LOAD_AVAIL : RES_AVAIL))
        stall = 1'b1;
  end
  assign in_ready = !reset && !hold && !kill && !stall;
  always_comb begin
    fwd_a_hit = 1'b0;
    fwd_b_hit = 1'b0;
    opa = rf_a;
    opb = rf_b;
    for (int k = STAGES - 1; k >= 1; k--)
      if (v[0] && v[k] && rw[k] && rd[k] != '0 && k >= (ld[k] ? LOAD_AVAIL : RES_AVAIL)) begin
        if (rd[k] == rs1) begin
          fwd_a_hit = 1'b1;
          opa = stage_result[k*DATA_W +: DATA_W];
        end
        if (rd[k] == rs2) begin
          fwd_b_hit = 1'b1;
          opb = stage_result[k*DATA_W +: DATA_W];
        end
      end
  end
  always_ff @(posedge clk)
    if (reset) begin
      v <= '0;
      rw <= '0;
      ld <= '0;
      rs1 <= '0;
      rs2 <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pl[k] <= '0;
        rd[k] <= '0;
      end
    end else if (hold) begin
      for (int k = 0; k < BR_STAGE; k++)
        if (kill) v[k] <= 1'b0;
    end else begin
      v[0] <= in_valid && in_ready;
      pl[0] <= in_payload;
      rd[0] <= in_rd;
      rw[0] <= in_regwrite;
      ld[0] <= in_is_load;
      rs1 <= in_rs1;
      rs2 <= in_rs2;
      for (int k = 1; k < STAGES; k++) begin
        v[k] <= v[k-1] && !(kill && k <= BR_STAGE);
        pl[k] <= pl[k-1];
        rd[k] <= rd[k-1];
        rw[k] <= rw[k-1];
        ld[k] <= ld[k-1];
      end
    end
  for (genvar i = 0; i < STAGES; i++) begin : g_pl
    assign stage_payload[i*PAYLOAD_W +: PAYLOAD_W] = pl[i];
  end
  assign stage_valid = v;
  assign wb_en = v[STAGES-1] && rw[STAGES-1] && rd[STAGES-1] != '0;
  assign wb_rd = rd[STAGES-1];
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      perf_retired <= '0;
      perf_stall_cyc <= '0;
      perf_kill_cyc <= '0;
    end else begin
      perf_retired <= perf_retired + 32'(v[STAGES-1] && !hold && perf_retired != '1);
      perf_stall_cyc <= perf_stall_cyc + 32'(in_valid && stall && perf_stall_cyc != '1);
      perf_kill_cyc <= perf_kill_cyc + 32'(kill && perf_kill_cyc != '1);
    end
`endif
endmodule
